// File: rtl/hls_run_ctrl_if.sv
// Host-side bundle of hls_run_ctrl: word-load handshake, run request and per-run results.
// HLS_RUN_CTRL_STATS_EN adds the run statistics outputs.
interface hls_run_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int RUN_W  = 8
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [7:0]        ld_size;
  logic              run_req;
  logic [RUN_W-1:0]  run_count;
  logic              busy;
  logic              res_valid;
  logic [CNT_W-1:0]  res_cycles;
  logic [RUN_W-1:0]  res_index;
  logic              res_timeout;
`ifdef HLS_RUN_CTRL_STATS_EN
  logic [CNT_W-1:0]       stat_min;
  logic [CNT_W-1:0]       stat_max;
  logic [CNT_W+RUN_W-1:0] stat_sum;
`endif

  modport master (
    output ld_valid, ld_addr, ld_data, ld_size, run_req, run_count,
    input  ld_ready, busy, res_valid, res_cycles, res_index, res_timeout
`ifdef HLS_RUN_CTRL_STATS_EN
    , input stat_min, stat_max, stat_sum
`endif
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_size, run_req, run_count,
    output ld_ready, busy, res_valid, res_cycles, res_index, res_timeout
`ifdef HLS_RUN_CTRL_STATS_EN
    , output stat_min, stat_max, stat_sum
`endif
  );
endinterface

// File: rtl/hls_run_ctrl.sv
// Run controller for a Bambu accelerator: host word loads, back-to-back timed runs, watchdog abort.
// Defining HLS_RUN_CTRL_STATS_EN adds min/max/sum statistics over non-timeout runs.
module hls_run_ctrl #(
  parameter int          N_CH    = 2,
  parameter int          ADDR_W  = 14,
  parameter int          DATA_W  = 16,
  parameter int          CNT_W   = 32,
  parameter int          RUN_W   = 8,
  parameter int unsigned TIMEOUT = 200000000
) (
  input  logic                     clock,
  input  logic                     reset,
  hls_run_ctrl_if.slave            host,
  output logic                     start_port,
  input  logic                     done_port,
  output logic                     acc_resetn,
  output logic [N_CH-1:0]          S_oe_ram,
  output logic [N_CH-1:0]          S_we_ram,
  output logic [N_CH*ADDR_W-1:0]   S_addr_ram,
  output logic [N_CH*DATA_W-1:0]   S_Wdata_ram,
  output logic [N_CH*8-1:0]        S_data_ram_size,
  input  logic [N_CH-1:0]          Sout_DataRdy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [RUN_W-1:0] ONE_R = RUN_W'(1);

  logic [2:0]        state;
  logic              alive;
  logic [CNT_W-1:0]  cnt;
  logic [RUN_W-1:0]  runs_left;
  logic [RUN_W-1:0]  run_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        size_q;
  logic              abort_cnt;
  logic              res_vld_q;
  logic [CNT_W-1:0]  res_cyc_q;
  logic [RUN_W-1:0]  res_idx_q;
  logic              res_to_q;
  logic              run_acc;
  logic              ld_acc;
  logic              done_hit;
  logic [CNT_W-1:0]  run_len;
  logic              unused_rdy;

  assign unused_rdy = ^Sout_DataRdy;

  // alive keeps ld_ready and acc_resetn low until the first cycle after reset releases
  assign host.ld_ready    = alive && (state == S_IDLE) && !host.run_req;
  assign host.busy        = (state != S_IDLE);
  assign host.res_valid   = res_vld_q;
  assign host.res_cycles  = res_cyc_q;
  assign host.res_index   = res_idx_q;
  assign host.res_timeout = res_to_q;
  assign start_port       = (state == S_START);
  assign acc_resetn       = alive && (state != S_ABORT);

  assign run_acc  = alive && (state == S_IDLE) && host.run_req;
  assign ld_acc   = host.ld_valid && host.ld_ready;
  assign done_hit = (state == S_RUN) && done_port;
  assign run_len  = cnt + ONE_C;

  always_comb begin
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    if (state == S_WRITE) begin
      S_we_ram[0]               = 1'b1;
      S_addr_ram[ADDR_W-1:0]    = addr_q;
      S_Wdata_ram[DATA_W-1:0]   = data_q;
      S_data_ram_size[7:0]      = size_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      alive     <= 1'b0;
      cnt       <= '0;
      runs_left <= '0;
      run_idx   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      abort_cnt <= 1'b0;
      res_vld_q <= 1'b0;
      res_cyc_q <= '0;
      res_idx_q <= '0;
      res_to_q  <= 1'b0;
    end else begin
      alive     <= 1'b1;
      res_vld_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run_acc) begin
            runs_left <= (host.run_count == '0) ? ONE_R : host.run_count;
            run_idx   <= '0;
            state     <= S_START;
          end else if (ld_acc) begin
            addr_q <= host.ld_addr;
            data_q <= host.ld_data;
            size_q <= host.ld_size;
            cnt    <= ONE_C;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (Sout_DataRdy[0]) begin
            state <= S_IDLE;
          end else if (cnt == TO) begin
            res_vld_q <= 1'b1;
            res_to_q  <= 1'b1;
            res_cyc_q <= TO;
            res_idx_q <= '0;
            abort_cnt <= 1'b0;
            state     <= S_ABORT;
          end else begin
            cnt <= run_len;
          end
        end
        S_START: begin
          cnt   <= ONE_C;
          state <= S_RUN;
        end
        S_RUN: begin
          // done takes priority over a watchdog expiring in the same cycle
          if (done_hit) begin
            res_vld_q <= 1'b1;
            res_to_q  <= 1'b0;
            res_cyc_q <= run_len;
            res_idx_q <= run_idx;
            if (runs_left > ONE_R) begin
              runs_left <= runs_left - ONE_R;
              run_idx   <= run_idx + ONE_R;
              state     <= S_GAP;
            end else begin
              runs_left <= '0;
              state     <= S_IDLE;
            end
          end else if (cnt == TO) begin
            res_vld_q <= 1'b1;
            res_to_q  <= 1'b1;
            res_cyc_q <= TO;
            res_idx_q <= run_idx;
            runs_left <= '0;
            abort_cnt <= 1'b0;
            state     <= S_ABORT;
          end else begin
            cnt <= run_len;
          end
        end
        S_GAP: state <= S_START;
        S_ABORT: begin
          abort_cnt <= 1'b1;
          if (abort_cnt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HLS_RUN_CTRL_STATS_EN
  localparam int SUM_W = CNT_W + RUN_W;

  logic [CNT_W-1:0] stat_min_q;
  logic [CNT_W-1:0] stat_max_q;
  logic [SUM_W-1:0] stat_sum_q;

  assign host.stat_min = stat_min_q;
  assign host.stat_max = stat_max_q;
  assign host.stat_sum = stat_sum_q;

  // stats land together with res_valid so they are final by the time busy drops
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_min_q <= '1;
      stat_max_q <= '0;
      stat_sum_q <= '0;
    end else if (run_acc) begin
      stat_min_q <= '1;
      stat_max_q <= '0;
      stat_sum_q <= '0;
    end else if (done_hit) begin
      if (run_len < stat_min_q) stat_min_q <= run_len;
      if (run_len > stat_max_q) stat_max_q <= run_len;
      stat_sum_q <= stat_sum_q + SUM_W'(run_len);
    end
  end
`endif
endmodule

// File: tb/tb_hls_run_ctrl.sv
// Scoreboard bench for hls_run_ctrl: expected results queued at stimulus time, popped on res_valid.
module tb_hls_run_ctrl;
  localparam int N_CH = 2, ADDR_W = 14, DATA_W = 16, CNT_W = 32, RUN_W = 8;
  localparam int TMO = 20;

  typedef struct {
    logic [CNT_W-1:0] cyc;
    logic [RUN_W-1:0] idx;
    logic             to;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_port, done_port, acc_resetn;
  logic [N_CH-1:0]        S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [N_CH*ADDR_W-1:0] S_addr_ram;
  logic [N_CH*DATA_W-1:0] S_Wdata_ram;
  logic [N_CH*8-1:0]      S_data_ram_size;

  hls_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RUN_W(RUN_W)) hif ();

  hls_run_ctrl #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
                 .RUN_W(RUN_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .host(hif),
    .start_port(start_port), .done_port(done_port), .acc_resetn(acc_resetn),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lo_cnt = 0;
  int   last_res_cyc = 0;
  logic prev_start = 1'b0;
  int   start_cyc[$];
  int   acc_q[$];
  res_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // result monitor: pops the scoreboard on every res_valid pulse
  always @(negedge clock) begin
    if (acc_resetn === 1'b0) lo_cnt = lo_cnt + 1;
    if (start_port === 1'b1) begin
      chk("start_single", prev_start, 0);
      start_cyc.push_back(cyc);
    end
    prev_start = start_port;
    if (hif.res_valid === 1'b1) begin
      last_res_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("res_unexpected", hif.res_valid, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_cycles", hif.res_cycles, e.cyc);
        chk("res_index", hif.res_index, e.idx);
        chk("res_timeout", hif.res_timeout, e.to);
      end
    end
  end

  // accelerator model: done_port pulses in RUN cycle d after each start (d<0: never)
  always @(negedge clock) begin
    if (start_port === 1'b1) begin
      int d;
      d = (acc_q.size() == 0) ? -1 : acc_q.pop_front();
      if (d > 0) begin
        repeat (d) @(posedge clock);
        #1 done_port = 1'b1;
        @(posedge clock);
        #1 done_port = 1'b0;
      end
    end
  end

  task automatic push_exp(input int c, input int idx, input bit to);
    res_t e;
    e.cyc = CNT_W'(c);
    e.idx = RUN_W'(idx);
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [7:0] s);
    logic [N_CH*ADDR_W-1:0] ea;
    logic [N_CH*DATA_W-1:0] ed;
    logic [N_CH*8-1:0]      es;
    ea = '0; ea[ADDR_W-1:0] = a;
    ed = '0; ed[DATA_W-1:0] = d;
    es = '0; es[7:0] = s;
    hif.ld_valid = 1'b1; hif.ld_addr = a; hif.ld_data = d; hif.ld_size = s;
    @(negedge clock);
    chk("ld_ready_idle", hif.ld_ready, 1);
    @(posedge clock); #1 hif.ld_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) Sout_DataRdy = 2'b01;
      @(negedge clock);
      chk("wr_we", S_we_ram, 2'b01);
      chk("wr_addr", S_addr_ram, ea);
      chk("wr_data", S_Wdata_ram, ed);
      chk("wr_size", S_data_ram_size, es);
      chk("wr_ld_ready", hif.ld_ready, 0);
      @(posedge clock); #1;
    end
    Sout_DataRdy = 2'b00;
    @(negedge clock);
    chk("wr_done_we", S_we_ram, 2'b00);
    chk("wr_done_busy", hif.busy, 0);
    @(posedge clock); #1;
  endtask

  task automatic run_seq(input logic [RUN_W-1:0] rc, input bit with_ld, output int fall);
    hif.run_req = 1'b1; hif.run_count = rc; hif.ld_valid = with_ld;
    @(negedge clock);
    chk("run_ld_ready", hif.ld_ready, 0);
    @(posedge clock); #1 hif.run_req = 1'b0; hif.ld_valid = 1'b0;
    @(negedge clock);
    chk("run_busy", hif.busy, 1);
    chk("run_no_write", S_we_ram, 2'b00);
    for (int i = 0; i < 400 && hif.busy; i++) @(negedge clock);
    if (hif.busy !== 1'b0) chk("busy_fall_budget", hif.busy, 0);
    fall = cyc;
    @(posedge clock); #1;
  endtask

  initial begin
    int fall, s0, lo0;
    hif.ld_valid = 0; hif.ld_addr = '0; hif.ld_data = '0; hif.ld_size = '0;
    hif.run_req = 0; hif.run_count = '0;
    done_port = 0; Sout_DataRdy = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", hif.busy, 0);
    chk("rst_ld_ready", hif.ld_ready, 0);
    chk("rst_res_valid", hif.res_valid, 0);
    chk("rst_start", start_port, 0);
    chk("rst_acc_resetn", acc_resetn, 0);
    chk("rst_we", S_we_ram, 0);
    chk("rst_res_cycles", hif.res_cycles, 0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_acc_resetn", acc_resetn, 1);
    chk("post_rst_ld_ready", hif.ld_ready, 1);
    @(posedge clock); #1;

    do_load(14'h0010, 16'hBEEF, 8'd16);
    do_load(14'h3FFE, 16'h1234, 8'd8);

    acc_q = '{5}; push_exp(6, 0, 0); s0 = start_cyc.size();
    run_seq(1, 0, fall);
    chk("single_starts", start_cyc.size() - s0, 1);
    chk("single_busy_fall", fall, last_res_cyc);
    chk("single_sb_empty", exp_q.size(), 0);

    acc_q = '{2, 4, 1}; push_exp(3, 0, 0); push_exp(5, 1, 0); push_exp(2, 2, 0);
    s0 = start_cyc.size();
    run_seq(3, 0, fall);
    chk("multi_starts", start_cyc.size() - s0, 3);
    if (start_cyc.size() - s0 == 3) begin
      chk("multi_gap0", start_cyc[s0+1] - start_cyc[s0], 2 + 2);
      chk("multi_gap1", start_cyc[s0+2] - start_cyc[s0+1], 4 + 2);
    end
    chk("multi_sb_empty", exp_q.size(), 0);
`ifdef HLS_RUN_CTRL_STATS_EN
    chk("stat_min", hif.stat_min, 2);
    chk("stat_max", hif.stat_max, 5);
    chk("stat_sum", hif.stat_sum, 10);
`endif

    acc_q = '{-1}; push_exp(TMO, 0, 1); s0 = start_cyc.size(); lo0 = lo_cnt;
    run_seq(4, 0, fall);
    chk("to_acc_resetn_lo", lo_cnt - lo0, 2);
    chk("to_busy_fall", fall, last_res_cyc + 2);
    repeat (10) @(posedge clock); #1;
    chk("to_starts", start_cyc.size() - s0, 1);
    chk("to_sb_empty", exp_q.size(), 0);
`ifdef HLS_RUN_CTRL_STATS_EN
    chk("to_stat_min", hif.stat_min, {CNT_W{1'b1}});
`endif

    acc_q = '{3}; push_exp(4, 0, 0); s0 = start_cyc.size();
    run_seq(0, 0, fall);
    chk("rc0_starts", start_cyc.size() - s0, 1);
    chk("rc0_sb_empty", exp_q.size(), 0);

    acc_q = '{1}; push_exp(2, 0, 0); s0 = start_cyc.size();
    run_seq(1, 1, fall);
    chk("both_starts", start_cyc.size() - s0, 1);
    chk("both_sb_empty", exp_q.size(), 0);

    acc_q = '{-1};
    hif.run_req = 1'b1; hif.run_count = 8'd2;
    @(posedge clock); #1 hif.run_req = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_busy", hif.busy, 0);
    chk("midrst_res_valid", hif.res_valid, 0);
    chk("midrst_acc_resetn", acc_resetn, 0);
    chk("midrst_ld_ready", hif.ld_ready, 0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("midrst_rel_acc_resetn", acc_resetn, 1);
    chk("midrst_rel_ld_ready", hif.ld_ready, 1);
    repeat (30) @(posedge clock); #1;
    chk("midrst_idle", hif.busy, 0);
    acc_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/hls_run_ctrl.md
Name: hls_run_ctrl

Overview:
- Synthesizable run controller for a Bambu-generated accelerator top (`start_port`/`done_port` plus slave RAM port). It replaces file-driven testbench sequencing with an on-chip host interface.
- Loads words into accelerator memory through slave channel 0.
- Launches a programmable number of back-to-back runs and measures cycles per run.
- Applies a watchdog timeout and aborts the accelerator when it expires.

Parameters:
- N_CH, 2: slave channel count; only channel 0 is driven, the others are tied to 0.
- ADDR_W, 14: slave address width per channel.
- DATA_W, 16: slave data width per channel.
- CNT_W, 32: cycle counter width.
- RUN_W, 8: width of the run-count field.
- TIMEOUT, 200000000: watchdog limit in cycles; must be less than 2^CNT_W.

Ports:
- clock  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ld_valid  in  1  host write request.
- ld_ready  out  1  controller accepts the word this cycle.
- ld_addr  in  ADDR_W  target byte address.
- ld_data  in  DATA_W  write data.
- ld_size  in  8  access size in bits, forwarded unchanged.
- run_req  in  1  start a run sequence (single-cycle pulse).
- run_count  in  RUN_W  number of runs; 0 is treated as 1.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  one-cycle pulse per finished or aborted run.
- res_cycles  out  CNT_W  cycle count of that run.
- res_index  out  RUN_W  zero-based run index.
- res_timeout  out  1  qualifies res_valid: the run hit the watchdog.
- start_port  out  1  accelerator start.
- done_port  in  1  accelerator done.
- acc_resetn  out  1  accelerator reset, active-low.
- S_oe_ram  out  N_CH  slave output enable; always 0.
- S_we_ram  out  N_CH  slave write enable.
- S_addr_ram  out  N_CH*ADDR_W  slave address.
- S_Wdata_ram  out  N_CH*DATA_W  slave write data.
- S_data_ram_size  out  N_CH*8  slave access size.
- Sout_DataRdy  in  N_CH  slave completion.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All outputs go to 0 except acc_resetn, which is 0 while reset is 0 and 1 afterwards.
  - State becomes IDLE; counters and the run index clear.
  - Reset asserted mid-operation abandons the operation with no res_valid.
- State IDLE:
  - ld_ready = 1 unless run_req is 1 in the same cycle; run_req wins.
  - run_req=1: latch max(run_count,1) into runs_left, clear res_index, go to START.
  - ld_valid=1 with ld_ready=1: latch addr/data/size, go to WRITE.
- State WRITE:
  - Drive S_we_ram[0]=1 and channel-0 addr/data/size every cycle until Sout_DataRdy[0]=1 is sampled, then return to IDLE with S_we_ram=0 on the next cycle.
  - The watchdog runs here too. On TIMEOUT, go to ABORT with res_valid=1, res_timeout=1, res_index=0, res_cycles=TIMEOUT.
- State START:
  - start_port=1 for exactly one cycle; counter loads 1; go to RUN.
- State RUN:
  - Counter increments by 1 per cycle.
  - done_port=1 sampled with counter value c: next cycle res_valid=1, res_cycles=c+1, res_timeout=0.
    - Done in the first RUN cycle therefore reports 2.
  - Then decrement runs_left. If it is nonzero: increment res_index, spend one GAP cycle with start_port=0, go to START. Otherwise go to IDLE.
  - Counter reaches TIMEOUT without done: res_valid=1, res_timeout=1, res_cycles=TIMEOUT; remaining runs are discarded; go to ABORT.
  - done_port and the timeout in the same cycle: done wins.
- State ABORT:
  - acc_resetn=0 for exactly 2 cycles, then IDLE.
- res_cycles and res_index hold their values between res_valid pulses.
- done_port is ignored outside RUN.
- run_req and ld_valid are ignored while busy; ld_ready stays 0.

Optional Feature:
- Macro: HLS_RUN_CTRL_STATS_EN.
- With the macro defined, add outputs stat_min and stat_max (CNT_W each) and stat_sum (CNT_W+RUN_W).
  - All three clear when run_req is accepted.
  - They update from each non-timeout result in the cycle res_valid is high and are readable once busy falls.
  - stat_min reads all-ones if no valid run occurred.
- Without the macro, these ports and their registers do not exist.

Test Plan:
- Load path:
  - Stimulus: ld_valid with addr=0x0010, data=0xBEEF, size=16; Sout_DataRdy[0] answers 3 cycles later.
  - Required: S_we_ram=2'b01 with addr/data stable for exactly 4 cycles, ld_ready=0 during WRITE, then IDLE.
- Single run:
  - Stimulus: run_count=1; done_port pulses in the 5th RUN cycle.
  - Required: start_port high 1 cycle; res_valid once with res_cycles=6, res_index=0, res_timeout=0; busy falls the following cycle.
- Multi-run:
  - Stimulus: run_count=3; done after 2, 4 and 1 RUN cycles.
  - Required: res_cycles 3, 5, 2 with res_index 0, 1, 2; exactly one idle gap cycle between start_port pulses.
  - With HLS_RUN_CTRL_STATS_EN: stat_min=2, stat_max=5, stat_sum=10.
- Timeout:
  - Stimulus: TIMEOUT=20, run_count=4, done never asserted.
  - Required: res_valid once with res_timeout=1, res_cycles=20; acc_resetn low 2 cycles; no further start_port pulses.
- Edge cases:
  - run_count=0 → exactly one run.
  - run_req and ld_valid in the same cycle → run starts and ld_ready=0.
  - reset=0 mid-RUN → state IDLE, busy=0, no res_valid.
